fns_dec_seq: RTL and testbench

//  Parametrised, handshaked Fibonacci-numeral-system (FNS) decoder for the CAC receive path.

---
 rtl/fns_dec_seq.sv | 159 +++++++++++++++
 tb/tb_fns_dec_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_dec_seq.sv
// Fibonacci-numeral-system codeword decoder.
// Accepts one N-bit FNS codeword over a valid/ready handshake and accumulates its weighted
// value serially, MSB first, one bit per cycle. Also flags codewords that are not
// forbidden-pattern-free (contain 010 or 101 anywhere). The result is held on a valid/ready
// output port until the sink takes it.
module fns_dec_seq #(
  parameter int unsigned N      = 7,
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              fpf_err
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Fibonacci weight of bit k: 1, 1, 2, 3, 5, ... Evaluated at elaboration only.
  function automatic logic [DATA_W-1:0] fib_weight(input int unsigned k);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] t;
    a = {{(DATA_W-1){1'b0}}, 1'b1};
    b = {{(DATA_W-1){1'b0}}, 1'b1};
    for (int unsigned i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  logic [DATA_W-1:0] weight [N];

  for (genvar k = 0; k < N; k++) begin : g_weight
    assign weight[k] = fib_weight(k);
  end

  logic [1:0]        state_q, state_d;
  logic [N-1:0]      code_q, code_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              err_q, err_d;
  logic              in_ready_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] dataout_d;
  logic              fpf_err_d;

  logic              win_err;
  logic [DATA_W-1:0] term;
  logic [DATA_W-1:0] acc_sum;

  // Any 3-bit window equal to 010 or 101 makes the incoming codeword non-FPF.
  always_comb begin
    win_err = 1'b0;
    for (int unsigned k = 0; k + 2 < N; k++) begin
      if (codein[k +: 3] == 3'b010 || codein[k +: 3] == 3'b101) begin
        win_err = 1'b1;
      end
    end
  end

  // Weight contributed by the bit currently addressed by idx_q (mux, no multiplier).
  always_comb begin
    term = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IdxW'(k) && code_q[k]) begin
        term = weight[k];
      end
    end
  end

  assign acc_sum = acc_q + term;

  // Next-state logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    err_d       = err_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    dataout_d   = dataout;
    fpf_err_d   = fpf_err;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          code_d     = codein;
          acc_d      = '0;
          idx_d      = IdxW'(N - 1);
          err_d      = win_err;
          in_ready_d = 1'b0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_sum;
        if (idx_q == '0) begin
          // Last bit: publish the result directly so out_valid rises N edges after accept.
          dataout_d   = acc_sum;
          fpf_err_d   = err_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dataout   <= '0;
      fpf_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      dataout   <= dataout_d;
      fpf_err   <= fpf_err_d;
    end
  end

endmodule

// File: tb/tb_fns_dec_seq.sv
// Self-checking bench for fns_dec_seq: directed cases on an N=7 instance plus random
// back-to-back codewords on N=7 and N=12 instances, checked against a Fibonacci-sum model.
module tb_fns_dec_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [6:0] a_codein = '0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [5:0] a_dataout;
  logic       a_fpf_err;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [11:0] b_codein = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [8:0]  b_dataout;
  logic        b_fpf_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fns_dec_seq #(.N(7), .DATA_W(6)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .codein    (a_codein),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .dataout   (a_dataout),
    .fpf_err   (a_fpf_err)
  );

  fns_dec_seq #(.N(12), .DATA_W(9)) dut12 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .codein    (b_codein),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .dataout   (b_dataout),
    .fpf_err   (b_fpf_err)
  );

  // Reference: value is the sum of Fibonacci numbers at set bit positions.
  function automatic int model_val(input int n, input logic [15:0] code);
    int fib [16];
    int sum;
    fib[0] = 1;
    fib[1] = 1;
    for (int k = 2; k < 16; k++) fib[k] = fib[k-1] + fib[k-2];
    sum = 0;
    for (int k = 0; k < n; k++) if (code[k]) sum += fib[k];
    return sum;
  endfunction

  // Reference: a bit that differs from both neighbours forms 010 or 101.
  function automatic logic model_err(input int n, input logic [15:0] code);
    logic e;
    e = 1'b0;
    for (int k = 1; k < n - 1; k++) begin
      if (code[k] != code[k-1] && code[k] != code[k+1]) e = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the N=7 instance; hold = cycles of out_ready=0 in DONE.
  task automatic send7(input logic [6:0] code, input int hold, output int waited);
    int lat;
    int exp_v;
    logic exp_e;
    logic [5:0] got_v;
    logic got_e;
    exp_v = model_val(7, {9'd0, code});
    exp_e = model_err(7, {9'd0, code});
    waited = 0;
    while (!a_in_ready && waited < 50) begin
      step();
      waited++;
    end
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL n7_in_ready_wait: got %b want 1", a_in_ready);
    end
    a_in_valid = 1'b1;
    a_codein   = code;
    step();
    a_in_valid = 1'b0;
    a_codein   = 7'($urandom);
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL n7_busy_in_ready: got %b want 0", a_in_ready);
    end
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL n7_latency code=%b: got %0d want 7", code, lat);
    end
    n_checks++;
    if (a_dataout !== 6'(exp_v)) begin
      n_fail++;
      $display("FAIL n7_dataout code=%b: got %0d want %0d", code, a_dataout, exp_v);
    end
    n_checks++;
    if (a_fpf_err !== exp_e) begin
      n_fail++;
      $display("FAIL n7_fpf_err code=%b: got %b want %b", code, a_fpf_err, exp_e);
    end
    got_v = a_dataout;
    got_e = a_fpf_err;
    for (int h = 0; h < hold; h++) begin
      a_in_valid = 1'b1;
      a_codein   = ~code;
      step();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_dataout !== got_v || a_fpf_err !== got_e
          || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL n7_hold cyc=%0d: got v=%b d=%0d e=%b rdy=%b want v=1 d=%0d e=%b rdy=0",
                 h, a_out_valid, a_dataout, a_fpf_err, a_in_ready, got_v, got_e);
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL n7_out_handshake: got out_valid=%b in_ready=%b want 0/1",
               a_out_valid, a_in_ready);
    end
  endtask

  task automatic send12(input logic [11:0] code, output int waited);
    int lat;
    int exp_v;
    logic exp_e;
    exp_v = model_val(12, {4'd0, code});
    exp_e = model_err(12, {4'd0, code});
    waited = 0;
    while (!b_in_ready && waited < 50) begin
      step();
      waited++;
    end
    b_in_valid = 1'b1;
    b_codein   = code;
    step();
    b_in_valid = 1'b0;
    b_codein   = 12'($urandom);
    lat = 0;
    while (!b_out_valid && lat < 60) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat !== 12 || b_dataout !== 9'(exp_v) || b_fpf_err !== exp_e) begin
      n_fail++;
      $display("FAIL n12_result code=%b: got lat=%0d d=%0d e=%b want lat=12 d=%0d e=%b",
               code, lat, b_dataout, b_fpf_err, exp_v, exp_e);
    end
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_dataout !== 6'd0
        || a_fpf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_n7: got rdy=%b v=%b d=%0d e=%b want 1/0/0/0",
               a_in_ready, a_out_valid, a_dataout, a_fpf_err);
    end
    n_checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_dataout !== 9'd0
        || b_fpf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_n12: got rdy=%b v=%b d=%0d e=%b want 1/0/0/0",
               b_in_ready, b_out_valid, b_dataout, b_fpf_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    int w;
    send7(7'b1111111, 0, w);
    send7(7'b0000000, 0, w);
    send7(7'b1100000, 0, w);
    send7(7'b0110011, 0, w);
    send7(7'b0000011, 0, w);
    send7(7'b0010000, 0, w);
    send7(7'b1010000, 0, w);
  endtask

  task automatic test_hold();
    int w;
    send7(7'b1101101, 5, w);
  endtask

  task automatic test_reset_busy();
    bit seen;
    int w;
    a_in_valid = 1'b1;
    a_codein   = 7'b1111111;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_idle: got rdy=%b v=%b want 1/0", a_in_ready, a_out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_no_output: got out_valid seen=%b want 0", seen);
    end
    send7(7'b0001111, 0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 20; i++) begin
      send7(7'($urandom), i % 3, w);
      if (i > 0) begin
        n_checks++;
        if (w !== 0) begin
          n_fail++;
          $display("FAIL b2b_n7_ready_gap i=%0d: got %0d idle waits want 0", i, w);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      send12(12'($urandom), w);
      if (i > 0) begin
        n_checks++;
        if (w !== 0) begin
          n_fail++;
          $display("FAIL b2b_n12_ready_gap i=%0d: got %0d idle waits want 0", i, w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
